// File: rtl/snn_noc_pkg.sv
// rtl/snn_noc_pkg.sv - shared SNN NoC packet format and arbiter state type
// Purpose: packet width constants, packet layout and output-arbiter state enum.
// Ports: none (package).
package snn_noc_pkg;

    localparam int PACK_WIDTH = 44;
    localparam int ADDR_WIDTH = 4;

    // [43:40] destination address, [39:0] payload
    typedef struct packed {
        logic [ADDR_WIDTH-1:0]            dest;
        logic [PACK_WIDTH-ADDR_WIDTH-1:0] payload;
    } packet_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/router_out_arbiter_rr_pick.sv
// rtl/router_out_arbiter_rr_pick.sv - rotating-priority request picker
// Purpose: combinational round-robin encoder; first set req bit scanning
//          ptr, ptr+1, ... with wrap modulo NUM_REQ.
// Ports:
//   req        in  NUM_REQ  request vector
//   ptr        in  SRC_W    highest-priority index (must be < NUM_REQ)
//   gnt_onehot out NUM_REQ  one-hot winner, zero when no request
//   gnt_idx    out SRC_W    winner index, zero when no request
//   any        out 1        at least one request present
module rr_pick
    import snn_noc_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [SRC_W-1:0]   gnt_idx,
    output logic               any
);

    // One spare bit so ptr+k can exceed NUM_REQ-1 before the wrap subtract.
    localparam int SW1 = SRC_W + 1;

    logic [SW1-1:0]   sum;
    logic [SRC_W-1:0] idx;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        sum        = '0;
        idx        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + SW1'(k);
            if (sum >= SW1'(NUM_REQ)) begin
                sum = sum - SW1'(NUM_REQ);
            end
            idx = sum[SRC_W-1:0];
            if (!any && req[idx]) begin
                any             = 1'b1;
                gnt_idx         = idx;
                gnt_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/router_out_arbiter.sv
// rtl/router_out_arbiter.sv - round-robin arbiter for one router output channel
// Purpose: shares one output link among NUM_REQ packet sources, holding one
//          packet in an output register with valid/ready on both sides.
// Optional: ROUTER_ARB_STATS_EN adds grant_cnt / stall_cnt counters.
// Ports:
//   clk        in  1                   clock
//   reset      in  1                   async active-high reset
//   in_valid   in  NUM_REQ             per-requester valid
//   in_data    in  NUM_REQ*PACK_WIDTH  requester i at [i*PACK_WIDTH +: PACK_WIDTH]
//   in_ready   out NUM_REQ             per-requester accept (at most one high)
//   out_valid  out 1                   output register full
//   out_data   out PACK_WIDTH          held packet
//   out_src    out SRC_W               requester that supplied out_data
//   out_ready  in  1                   downstream consumes when out_valid=1
//   grant_cnt  out NUM_REQ*16          (stats) saturating per-requester grants
//   stall_cnt  out 16                  (stats) saturating out_valid&!out_ready cycles
module router_out_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int PACK_WIDTH = snn_noc_pkg::PACK_WIDTH,
    parameter int ADDR_WIDTH = snn_noc_pkg::ADDR_WIDTH,
    parameter int SRC_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            in_valid,
    input  logic [NUM_REQ*PACK_WIDTH-1:0] in_data,
    output logic [NUM_REQ-1:0]            in_ready,
    output logic                          out_valid,
    output logic [PACK_WIDTH-1:0]         out_data,
    output logic [SRC_W-1:0]              out_src,
`ifdef ROUTER_ARB_STATS_EN
    output logic [NUM_REQ*16-1:0]         grant_cnt,
    output logic [15:0]                   stall_cnt,
`endif
    input  logic                          out_ready
);
    import snn_noc_pkg::*;

    if (ADDR_WIDTH >= PACK_WIDTH || NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_cfg
        $error("router_out_arbiter: unsupported parameter combination");
    end

    arb_state_t              state_q, state_d;
    logic [SRC_W-1:0]        ptr_q, ptr_d;
    logic [SRC_W-1:0]        src_q, src_d;
    logic [PACK_WIDTH-1:0]   data_q, data_d;

    logic [NUM_REQ-1:0]      gnt_onehot;
    logic [SRC_W-1:0]        gnt_idx;
    logic                    any_req;
    logic                    can_load;
    logic                    grant;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .SRC_W   (SRC_W)
    ) u_rr_pick (
        .req        (in_valid),
        .ptr        (ptr_q),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (any_req)
    );

    // A full register can reload in the same cycle it is drained.
    assign can_load = (state_q == EMPTY) || out_ready;
    assign grant    = can_load && any_req;
    // Reset state already blocks loading, but EMPTY would otherwise still
    // advertise ready while reset is held.
    assign in_ready = (grant && !reset) ? gnt_onehot : '0;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        src_d   = src_q;
        data_d  = data_q;
        if (grant) begin
            state_d = FULL;
            src_d   = gnt_idx;
            data_d  = in_data[int'(gnt_idx)*PACK_WIDTH +: PACK_WIDTH];
            ptr_d   = (gnt_idx == SRC_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
        end else if (state_q == FULL && out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            src_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            src_q   <= src_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_src   = src_q;

`ifdef ROUTER_ARB_STATS_EN
    logic [15:0] stall_cnt_q;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_grant_cnt
        logic [15:0] cnt_q;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
            end else if (in_ready[g] && cnt_q != 16'hFFFF) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
        assign grant_cnt[g*16 +: 16] = cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (out_valid && !out_ready && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_router_out_arbiter.sv
// tb/tb_router_out_arbiter.sv - self-checking bench for router_out_arbiter
module tb_router_out_arbiter;
    import snn_noc_pkg::*;

    localparam int N  = 4;
    localparam int PW = 44;
    localparam int SW = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     in_valid;
    logic [N*PW-1:0]  in_data;
    logic [N-1:0]     in_ready;
    logic             out_valid;
    logic [PW-1:0]    out_data;
    logic [SW-1:0]    out_src;
    logic             out_ready;
`ifdef ROUTER_ARB_STATS_EN
    logic [N*16-1:0]  grant_cnt;
    logic [15:0]      stall_cnt;
`endif

    router_out_arbiter #(
        .NUM_REQ    (N),
        .PACK_WIDTH (PW),
        .ADDR_WIDTH (4),
        .SRC_W      (SW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
`ifdef ROUTER_ARB_STATS_EN
        .grant_cnt (grant_cnt),
        .stall_cnt (stall_cnt),
`endif
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int          src;
        logic [PW-1:0] data;
    } exp_t;

    exp_t sb[$];
    bit   m_full = 1'b0;
    int   m_ptr  = 0;

    // Reference model: evaluated at the falling edge, where inputs are stable
    // until the next rising edge; model state then reflects that edge.
    always @(negedge clk) begin
        int          pick;
        int          j;
        bit          can;
        logic [N-1:0] exp_rdy;
        exp_t        e;
        if (reset) begin
            m_full = 1'b0;
            m_ptr  = 0;
            sb.delete();
            check("rst_in_ready", 64'(in_ready), 64'd0);
            check("rst_out_valid", 64'(out_valid), 64'd0);
        end else begin
            can  = !m_full || out_ready;
            pick = -1;
            for (int s = 0; s < N; s++) begin
                j = (m_ptr + s) % N;
                if (pick < 0 && in_valid[j]) pick = j;
            end
            exp_rdy = '0;
            if (can && pick >= 0) exp_rdy[pick] = 1'b1;
            check("in_ready", 64'(in_ready), 64'(exp_rdy));
            check("out_valid", 64'(out_valid), 64'(m_full));
            if (m_full && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb_out_data", 64'(out_data), 64'(e.data));
                    check("sb_out_src", 64'(out_src), 64'(e.src));
                end
            end
            if (exp_rdy != '0) begin
                e.src  = pick;
                e.data = in_data[pick*PW +: PW];
                sb.push_back(e);
                m_full = 1'b1;
                m_ptr  = (pick + 1) % N;
            end else if (m_full && out_ready) begin
                m_full = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic set_pkt(input int i, input logic [PW-1:0] v);
        in_data[i*PW +: PW] = v;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [PW-1:0] pkt0;

    initial begin
        packet_t p;
        reset    = 1'b1;
        in_valid = '0;
        out_ready = 1'b0;
        in_data  = '0;
        for (int i = 0; i < N; i++) begin
            p.dest    = 4'(i + 4);
            p.payload = {8'(i), 32'($urandom)};
            set_pkt(i, p);
        end
        #1;
        check("rst_out_valid0", 64'(out_valid), 64'd0);
        check("rst_out_data0", 64'(out_data), 64'd0);
        check("rst_out_src0", 64'(out_src), 64'd0);
        do_reset();

        // single requester, then pointer skip and wrap
        in_valid  = 4'b0100;
        set_pkt(2, 44'h3_00000000FF);
        out_ready = 1'b1;
        neg();
        check("single_in_ready", 64'(in_ready), 64'b0100);
        step();
        in_valid = 4'b0010;
        neg();
        check("single_out_valid", 64'(out_valid), 64'd1);
        check("single_out_data", 64'(out_data), 64'h3_00000000FF);
        check("single_out_src", 64'(out_src), 64'd2);
        check("skip_in_ready", 64'(in_ready), 64'b0010);
        step();
        in_valid = 4'b1001;
        neg();
        check("skip_out_src", 64'(out_src), 64'd1);
        check("wrap_in_ready", 64'(in_ready), 64'b1000);
        step();
        in_valid = 4'b0001;
        neg();
        check("wrap_out_src", 64'(out_src), 64'd3);
        check("wrap_ptr0_in_ready", 64'(in_ready), 64'b0001);
        step();
        in_valid = '0;
        neg();
        check("wrap_last_src", 64'(out_src), 64'd0);
        step();
        step();

        // reset while FULL; pointer must restart at 0 (it is 1 here)
        in_valid  = 4'b0001;
        set_pkt(0, 44'hA_0000000001);
        out_ready = 1'b0;
        step();
        in_valid = 4'b1001;
        neg();
        check("prerst_out_data", 64'(out_data), 64'hA_0000000001);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_out_src", 64'(out_src), 64'd0);
        check("async_rst_in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        neg();
        check("post_rst_in_ready", 64'(in_ready), 64'b0001);
        step();
        in_valid = 4'b1000;
        neg();
        check("post_rst_src0", 64'(out_src), 64'd0);
        step();
        in_valid = '0;
        neg();
        check("post_rst_src3", 64'(out_src), 64'd3);
        step();
        step();

        // full contention, ptr is 0 here
        in_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step();
            if (k == 7) in_valid = '0;
            neg();
            check($sformatf("rr_valid_%0d", k), 64'(out_valid), 64'd1);
            check($sformatf("rr_src_%0d", k), 64'(out_src), 64'(k % 4));
        end
        step();

        // backpressure
        pkt0 = in_data[0 +: PW];
        in_valid  = 4'b0011;
        out_ready = 1'b0;
        step();
        in_valid = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            neg();
            check($sformatf("bp_data_%0d", k), 64'(out_data), 64'(pkt0));
            check($sformatf("bp_ready_%0d", k), 64'(in_ready), 64'd0);
            step();
        end
        out_ready = 1'b1;
        neg();
        check("bp_release_ready", 64'(in_ready), 64'b0010);
        step();
        in_valid = '0;
        neg();
        check("bp_release_src", 64'(out_src), 64'd1);
        step();
        step();

        // 3 grants to requester 1 and 4 stall cycles from a clean reset
        do_reset();
        in_valid = 4'b0010;
        step();
        repeat (4) step();
        out_ready = 1'b1;
        step();
        step();
        in_valid = '0;
        step();
        neg();
        check("stats_empty", 64'(out_valid), 64'd0);
`ifdef ROUTER_ARB_STATS_EN
        check("grant_cnt0", 64'(grant_cnt[0 +: 16]), 64'd0);
        check("grant_cnt1", 64'(grant_cnt[16 +: 16]), 64'd3);
        check("grant_cnt2", 64'(grant_cnt[32 +: 16]), 64'd0);
        check("grant_cnt3", 64'(grant_cnt[48 +: 16]), 64'd0);
        check("stall_cnt", 64'(stall_cnt), 64'd4);
`endif
        check("sb_drained", 64'(sb.size()), 64'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
